// File: rtl/signal_measure_ctrl_pkg.sv
// Shared constants, state encoding and helpers for the single-period
// frequency / duty-cycle meter (signal_measure_ctrl).
`timescale 1ns/1ps
package signal_measure_ctrl_pkg;

    // Result and counter widths
    localparam int FREQ_W     = 26;
    localparam int TIME_W     = 20;
    localparam int DUTY_W     = 8;
    localparam int PERIOD_W   = TIME_W + 1;
    localparam int DIVIDEND_W = 32;

    // Duty scaling factor (percent)
    localparam int unsigned PCT_SCALE = 100;

    // Counter ceiling; also the cycle count at which a wait gives up when the
    // timeout option is built in
    localparam logic [TIME_W-1:0] TIME_MAX      = '1;
    localparam logic [TIME_W-1:0] TIMEOUT_LIMIT = TIME_MAX;

    // Measurement FSM encoding
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_RISE = 3'd1;
    localparam logic [2:0] ST_HIGH      = 3'd2;
    localparam logic [2:0] ST_LOW       = 3'd3;
    localparam logic [2:0] ST_DIV       = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

    // Increment that sticks at the counter ceiling
    function automatic logic [TIME_W-1:0] sat_inc(input logic [TIME_W-1:0] v);
        return (v == TIME_MAX) ? v : v + 20'd1;
    endfunction

endpackage

// File: rtl/signal_measure_ctrl_if.sv
// Bundle of the meter's start/measure/result signals.
// slave  : the meter itself; master : whoever drives enable/sig_in.
`timescale 1ns/1ps
interface signal_measure_ctrl_if;
    import signal_measure_ctrl_pkg::*;

    logic              enable;
    logic              sig_in;
    logic              busy;
    logic              finish;
    logic [FREQ_W-1:0] freq;
    logic [DUTY_W-1:0] duty;
    logic [TIME_W-1:0] high_time;
    logic [TIME_W-1:0] low_time;

    modport slave (
        input  enable, sig_in,
        output busy, finish, freq, duty, high_time, low_time
    );

    modport master (
        output enable, sig_in,
        input  busy, finish, freq, duty, high_time, low_time
    );

endinterface

// File: rtl/signal_measure_ctrl_divider.sv
// seq_divider: unsigned restoring divider, one quotient bit per cycle.
// Only the low Q_W quotient bits are produced; the caller guarantees that
// dividend / divisor < 2^Q_W, so the upper dividend bits seed the partial
// remainder directly. done pulses for one cycle with quotient valid.
`timescale 1ns/1ps
module seq_divider
    import signal_measure_ctrl_pkg::*;
#(
    parameter int N_W = DIVIDEND_W,
    parameter int D_W = PERIOD_W,
    parameter int Q_W = FREQ_W
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N_W-1:0] dividend,
    input  logic [D_W-1:0] divisor,
    output logic           done,
    output logic [Q_W-1:0] quotient
);

    localparam int CNT_W = $clog2(Q_W + 1);

    logic             active_q, active_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [D_W-1:0]   rem_q, rem_d;
    logic [D_W-1:0]   dvs_q, dvs_d;
    logic [Q_W-1:0]   quo_q, quo_d;
    logic [D_W:0]     trial;
    logic [D_W:0]     diff;

    // One restoring step per cycle: shift in the next dividend bit, subtract if it fits
    always_comb begin
        trial    = {rem_q, quo_q[Q_W-1]};
        diff     = trial - {1'b0, dvs_q};
        active_d = active_q;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        quo_d    = quo_q;
        if (start) begin
            rem_d    = D_W'(dividend[N_W-1:Q_W]);
            quo_d    = dividend[Q_W-1:0];
            dvs_d    = divisor;
            cnt_d    = CNT_W'(Q_W);
            active_d = 1'b1;
        end else if (active_q) begin
            if (trial >= {1'b0, dvs_q}) begin
                rem_d = diff[D_W-1:0];
                quo_d = {quo_q[Q_W-2:0], 1'b1};
            end else begin
                rem_d = trial[D_W-1:0];
                quo_d = {quo_q[Q_W-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                active_d = 1'b0;
                done_d   = 1'b1;
            end
        end
    end

    // Control state of the divider
    always_ff @(posedge clk) begin
        if (rst) begin
            active_q <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            active_q <= active_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
        end
    end

    // Datapath registers; only meaningful while active, so no reset
    always_ff @(posedge clk) begin
        rem_q <= rem_d;
        dvs_q <= dvs_d;
        quo_q <= quo_d;
    end

    assign done     = done_q;
    assign quotient = quo_q;

endmodule

// File: rtl/signal_measure_ctrl.sv
// signal_measure_ctrl: times one high phase and the following low phase of an
// asynchronous input, then divides to get frequency (Hz) and duty (percent).
// Optional build macro SIGNAL_MEASURE_TIMEOUT_EN: any wait/count state that
// reaches 2^20-1 cycles ends the measurement with freq = duty = 0.
// CLK_FREQ must stay below 2^26 so the frequency quotient fits FREQ_W bits.
`timescale 1ns/1ps
module signal_measure_ctrl
    import signal_measure_ctrl_pkg::*;
#(
    parameter int unsigned CLK_FREQ = 50_000_000
) (
    input  logic                  clk,
    input  logic                  rst,
    signal_measure_ctrl_if.slave  bus
);

    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              sync3_q, sync3_d;
    logic              rise;
    logic              fall;

    logic [2:0]        state_q, state_d;
    logic [TIME_W-1:0] high_cnt_q, high_cnt_d;
    logic [TIME_W-1:0] low_cnt_q, low_cnt_d;
    logic              div_sel_q, div_sel_d;
    logic              div_go_q, div_go_d;
    logic [FREQ_W-1:0] freq_res_q, freq_res_d;
    logic [DUTY_W-1:0] duty_res_q, duty_res_d;
    logic              busy_q, busy_d;
    logic              finish_q, finish_d;
    logic [FREQ_W-1:0] freq_q, freq_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [TIME_W-1:0] high_time_q, high_time_d;
    logic [TIME_W-1:0] low_time_q, low_time_d;

    logic [PERIOD_W-1:0]   period;
    logic [DIVIDEND_W-1:0] div_dividend;
    logic                  div_done;
    logic [FREQ_W-1:0]     div_quot;

    logic wait_tmo;
    logic high_tmo;
    logic low_tmo;

    // Two-stage synchroniser followed by the edge-detect register
    always_comb begin
        sync1_d = bus.sig_in;
        sync2_d = sync1_q;
        sync3_d = sync2_q;
    end

    assign rise = sync2_q & ~sync3_q;
    assign fall = ~sync2_q & sync3_q;

    assign period = {1'b0, high_cnt_q} + {1'b0, low_cnt_q};

    // Dividend for the current division: clock rate first, then scaled high time
    always_comb begin
        if (div_sel_q) begin
            div_dividend = DIVIDEND_W'(high_cnt_q) * PCT_SCALE;
        end else begin
            div_dividend = DIVIDEND_W'(CLK_FREQ);
        end
    end

`ifdef SIGNAL_MEASURE_TIMEOUT_EN
    logic [TIME_W-1:0] wait_cnt_q, wait_cnt_d;

    // Cycles spent waiting for the first rising edge
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (state_q == ST_IDLE) begin
            wait_cnt_d = '0;
        end else if (state_q == ST_WAIT_RISE) begin
            wait_cnt_d = sat_inc(wait_cnt_q);
        end
    end

    // Wait counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign wait_tmo = (wait_cnt_q == TIMEOUT_LIMIT);
    assign high_tmo = (high_cnt_q == TIMEOUT_LIMIT);
    assign low_tmo  = (low_cnt_q == TIMEOUT_LIMIT);
`else
    // Without the timeout option the FSM waits for edges indefinitely
    assign wait_tmo = 1'b0;
    assign high_tmo = 1'b0;
    assign low_tmo  = 1'b0;
`endif

    // Measurement FSM: arm, time high then low, two divisions, publish results
    always_comb begin
        state_d     = state_q;
        high_cnt_d  = high_cnt_q;
        low_cnt_d   = low_cnt_q;
        div_sel_d   = div_sel_q;
        div_go_d    = 1'b0;
        freq_res_d  = freq_res_q;
        duty_res_d  = duty_res_q;
        busy_d      = 1'b1;
        finish_d    = 1'b0;
        freq_d      = freq_q;
        duty_d      = duty_q;
        high_time_d = high_time_q;
        low_time_d  = low_time_q;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                // The finish cycle is still part of the previous run
                if (bus.enable && !finish_q) begin
                    state_d    = ST_WAIT_RISE;
                    busy_d     = 1'b1;
                    high_cnt_d = '0;
                    low_cnt_d  = '0;
                end
            end
            ST_WAIT_RISE: begin
                if (rise) begin
                    state_d    = ST_HIGH;
                    high_cnt_d = TIME_W'(1);
                end else if (wait_tmo) begin
                    state_d    = ST_DONE;
                    freq_res_d = '0;
                    duty_res_d = '0;
                end
            end
            ST_HIGH: begin
                if (fall) begin
                    state_d   = ST_LOW;
                    low_cnt_d = TIME_W'(1);
                end else if (high_tmo) begin
                    state_d    = ST_DONE;
                    freq_res_d = '0;
                    duty_res_d = '0;
                end else begin
                    high_cnt_d = sat_inc(high_cnt_q);
                end
            end
            ST_LOW: begin
                if (rise) begin
                    if (period == '0) begin
                        state_d    = ST_DONE;
                        freq_res_d = '0;
                        duty_res_d = '0;
                    end else begin
                        state_d   = ST_DIV;
                        div_sel_d = 1'b0;
                        div_go_d  = 1'b1;
                    end
                end else if (low_tmo) begin
                    state_d    = ST_DONE;
                    freq_res_d = '0;
                    duty_res_d = '0;
                end else begin
                    low_cnt_d = sat_inc(low_cnt_q);
                end
            end
            ST_DIV: begin
                if (div_done) begin
                    if (!div_sel_q) begin
                        freq_res_d = div_quot;
                        div_sel_d  = 1'b1;
                        div_go_d   = 1'b1;
                    end else begin
                        duty_res_d = div_quot[DUTY_W-1:0];
                        state_d    = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                freq_d      = freq_res_q;
                duty_d      = duty_res_q;
                high_time_d = high_cnt_q;
                low_time_d  = low_cnt_q;
                finish_d    = 1'b1;
                state_d     = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All state, counters and published results; reset aborts any measurement
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            sync3_q     <= 1'b0;
            state_q     <= ST_IDLE;
            high_cnt_q  <= '0;
            low_cnt_q   <= '0;
            div_sel_q   <= 1'b0;
            div_go_q    <= 1'b0;
            freq_res_q  <= '0;
            duty_res_q  <= '0;
            busy_q      <= 1'b0;
            finish_q    <= 1'b0;
            freq_q      <= '0;
            duty_q      <= '0;
            high_time_q <= '0;
            low_time_q  <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sync3_q     <= sync3_d;
            state_q     <= state_d;
            high_cnt_q  <= high_cnt_d;
            low_cnt_q   <= low_cnt_d;
            div_sel_q   <= div_sel_d;
            div_go_q    <= div_go_d;
            freq_res_q  <= freq_res_d;
            duty_res_q  <= duty_res_d;
            busy_q      <= busy_d;
            finish_q    <= finish_d;
            freq_q      <= freq_d;
            duty_q      <= duty_d;
            high_time_q <= high_time_d;
            low_time_q  <= low_time_d;
        end
    end

    seq_divider #(
        .N_W (DIVIDEND_W),
        .D_W (PERIOD_W),
        .Q_W (FREQ_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_go_q),
        .dividend (div_dividend),
        .divisor  (period),
        .done     (div_done),
        .quotient (div_quot)
    );

    assign bus.busy      = busy_q;
    assign bus.finish    = finish_q;
    assign bus.freq      = freq_q;
    assign bus.duty      = duty_q;
    assign bus.high_time = high_time_q;
    assign bus.low_time  = low_time_q;

endmodule

// File: tb/tb_signal_measure_ctrl.sv
// Bench for signal_measure_ctrl: drives a periodic sig_in whose phase lengths
// are whole clock periods, and predicts freq/duty/high/low from those lengths.
`timescale 1ns/1ps
module tb_signal_measure_ctrl;

    localparam int CLK_HZ = 50_000_000;
    localparam int CLK_NS = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_tests = 0;
    int n_fail  = 0;
    int fin_cnt = 0;

    // Generator control: phase lengths in clock cycles, or held low
    int hi_cyc = 40;
    int lo_cyc = 60;
    bit stuck  = 1'b0;

    signal_measure_ctrl_if bus();

    signal_measure_ctrl #(.CLK_FREQ(CLK_HZ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #(CLK_NS/2) clk = ~clk;

    // Input waveform; edges sit 7 ns before a rising clock edge
    initial begin
        int h;
        int l;
        bus.sig_in = 1'b0;
        #3;
        forever begin
            if (stuck) begin
                bus.sig_in = 1'b0;
                #(CLK_NS);
            end else begin
                h = hi_cyc;
                l = lo_cyc;
                bus.sig_in = 1'b1;
                #(h * CLK_NS);
                bus.sig_in = 1'b0;
                #(l * CLK_NS);
            end
        end
    end

    always @(negedge clk) begin
        if (bus.finish === 1'b1) fin_cnt <= fin_cnt + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic pulse_enable();
        @(negedge clk);
        bus.enable = 1'b1;
        @(negedge clk);
        bus.enable = 1'b0;
    endtask

    task automatic set_pattern(input int h, input int l);
        hi_cyc = h;
        lo_cyc = l;
        repeat (h + l + 450) @(negedge clk);
    endtask

    task automatic wait_finish(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.finish === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // One measurement of an h-high / l-low waveform against plain arithmetic
    task automatic measure(input int h, input int l, input bit extra_en);
        int exp_f;
        int exp_d;
        int base;
        bit ok;
        exp_f = CLK_HZ / (h + l);
        exp_d = (h * 100) / (h + l);
        base  = fin_cnt;
        pulse_enable();
        if (extra_en) begin
            repeat (4) @(negedge clk);
            check_val("busy_while_measuring", bus.busy, 1);
            pulse_enable();
        end
        wait_finish(2 * (h + l) + 200, ok);
        check_val("finish_seen", ok, 1);
        if (ok) begin
            check_val("freq", bus.freq, exp_f);
            check_val("duty", bus.duty, exp_d);
            check_val("high_time", bus.high_time, h);
            check_val("low_time", bus.low_time, l);
            check_val("busy_at_finish", bus.busy, 1);
            @(negedge clk);
            check_val("busy_after_finish", bus.busy, 0);
            check_val("finish_one_cycle", bus.finish, 0);
        end
        if (extra_en) begin
            repeat (2 * (h + l) + 100) @(negedge clk);
            check_val("single_finish", fin_cnt - base, 1);
            check_val("freq_held", bus.freq, exp_f);
            check_val("duty_held", bus.duty, exp_d);
        end
    endtask

    initial begin
        bit seen;
        bit prev;
        int base;
        bit ok;
        bus.enable = 1'b0;
        rst = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_finish", bus.finish, 0);
        check_val("rst_freq", bus.freq, 0);
        check_val("rst_duty", bus.duty, 0);
        check_val("rst_high", bus.high_time, 0);
        check_val("rst_low", bus.low_time, 0);

        // 500 kHz, 40 %
        measure(40, 60, 1'b0);

        // 1 MHz, 50 %, after 20 us
        hi_cyc = 25;
        lo_cyc = 25;
        repeat (1000) @(negedge clk);
        measure(25, 25, 1'b0);

        // Second enable while busy must be ignored
        measure(25, 25, 1'b1);

        // Reset in the middle of the high phase
        set_pattern(100, 100);
        pulse_enable();
        seen = 1'b0;
        prev = bus.sig_in;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (bus.sig_in && !prev) begin
                seen = 1'b1;
                break;
            end
            prev = bus.sig_in;
        end
        check_val("rise_before_abort", seen, 1);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_val("abort_busy", bus.busy, 0);
        check_val("abort_finish", bus.finish, 0);
        check_val("abort_freq", bus.freq, 0);
        check_val("abort_duty", bus.duty, 0);
        check_val("abort_high", bus.high_time, 0);
        check_val("abort_low", bus.low_time, 0);
        base = fin_cnt;
        repeat (500) @(negedge clk);
        check_val("abort_no_finish", fin_cnt - base, 0);
        measure(100, 100, 1'b0);

        // Boundary shapes: shortest period and extreme duty
        set_pattern(1, 1);
        measure(1, 1, 1'b0);
        set_pattern(199, 1);
        measure(199, 1, 1'b0);
        set_pattern(1, 199);
        measure(1, 199, 1'b0);

        // Randomised waveforms
        for (int k = 0; k < 8; k++) begin
            int h;
            int l;
            h = $urandom_range(1, 200);
            l = $urandom_range(1, 200);
            set_pattern(h, l);
            measure(h, l, 1'b0);
        end

        // Input stuck low
        stuck = 1'b1;
        repeat (450) @(negedge clk);
        base = fin_cnt;
        pulse_enable();
`ifdef SIGNAL_MEASURE_TIMEOUT_EN
        wait_finish((1 << 20) + 400, ok);
        check_val("timeout_finish", ok, 1);
        check_val("timeout_freq", bus.freq, 0);
        check_val("timeout_duty", bus.duty, 0);
        check_val("timeout_high", bus.high_time, 0);
        check_val("timeout_low", bus.low_time, 0);
`else
        ok = 1'b0;
        repeat (20000) @(negedge clk);
        check_val("stuck_busy", bus.busy, 1);
        check_val("stuck_no_finish", fin_cnt - base, 0);
`endif
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stuck = 1'b0;
        @(negedge clk);
        check_val("final_busy", bus.busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
